// File: rtl/muller_c_pkg.sv
// Shared types and defaults for the Muller C-element receive path.
package muller_c_pkg;

    localparam int unsigned DefDataW      = 4;
    localparam int unsigned DefDepth      = 4;
    localparam int unsigned DefSyncStages = 2;

    typedef enum logic [1:0] {
        StIdle,
        StStall,
        StAckHi
    } rx_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/muller_c_sync.sv
// Flop-chain synchroniser for an asynchronous level entering the clock domain.
module muller_c_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain_q;

    // The first flop samples async_in directly; nothing may sit in front of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/muller_c_rx_fifo.sv
// 4-phase handshake receiver for the C-element loop, buffering captured words
// in a small FIFO drained through a valid/ready stream.
module muller_c_rx_fifo
    import muller_c_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   c_in,
    input  logic [DATA_W-1:0]      data_in,
    output logic                   ack_out,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]       xfer_cnt,
    output logic                   stall
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic              c_sync;
    rx_state_e         state_q, state_d;
    logic              push, pop, full;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  xfer_cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    muller_c_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_c_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(c_in),
        .sync_out(c_sync)
    );

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == PW'(DEPTH));
    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (c_sync) begin
                    if (!full) begin
                        push    = 1'b1;
                        state_d = StAckHi;
                    end else begin
                        state_d = StStall;
                    end
                end
            end
            // A request dropped while stalled is still captured once space frees.
            StStall: begin
                if (!full) begin
                    push    = 1'b1;
                    state_d = StAckHi;
                end
            end
            StAckHi: begin
                if (!c_sync) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            xfer_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_in;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
                xfer_cnt_q              <= xfer_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign ack_out  = (state_q == StAckHi);
    assign stall    = (state_q == StStall);
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: doc/muller_c_rx_fifo.md
Name: muller_c_rx_fifo

Overview:
- Downstream consumer of the Muller C-element stage.
- Synchronises the C-element's asynchronous output into the clock domain and acts as the 4-phase handshake receiver.
- Captures the bundled data word on each completed request into a small FIFO, which drains to the management side through a valid/ready stream.
- Returns ack to the upstream C-element loop; back-pressures upstream by withholding ack when the FIFO is full.

Parameters:
DATA_W, 4, width of bundled data word from io_in
DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, flops in the c_in synchroniser; >=2
CNT_W, 16, width of transfer counter

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
c_in  in  1  C-element output (request), asynchronous level
data_in  in  DATA_W  bundled data; stable from before c_in rises until ack_out rises
ack_out  out  1  4-phase acknowledge to upstream
m_data  out  DATA_W  FIFO head word
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid&m_ready
level  out  clog2(DEPTH)+1  current FIFO occupancy
xfer_cnt  out  CNT_W  completed captures, wraps modulo 2^CNT_W
stall  out  1  high while a request is held off because the FIFO is full

Behaviour:
- Reset is asynchronous and active-low: all flops clear immediately on rst_n low.
  - Reset values: ack_out=0, m_valid=0, m_data=0, level=0, xfer_cnt=0, stall=0; synchroniser=0; FSM=IDLE.
- Synchroniser: c_sync is c_in delayed by SYNC_STAGES flops. No logic before the first flop.
- data_in is sampled raw, with no synchroniser, at the push edge. This is safe because data has been stable for >=SYNC_STAGES cycles.
- FSM (registered ack_out = 1 only in ACK_HI):
  - IDLE:
    - c_sync=1 and not full -> push data_in, xfer_cnt+1, go ACK_HI.
    - c_sync=1 and full -> go STALL.
    - Otherwise stay.
  - STALL: stall=1. When not full (level < DEPTH, registered) -> push, xfer_cnt+1, go ACK_HI.
  - ACK_HI: ack_out=1. When c_sync=0 -> go IDLE (ack_out=0 the next cycle).
- Exactly one push per c_in high phase. A c_in pulse narrower than SYNC_STAGES cycles may be missed; this is not an error.
- Latency:
  - c_in rise to push edge = SYNC_STAGES cycles (IDLE, FIFO not full).
  - ack_out high 1 cycle after push.
  - m_valid high 1 cycle after push into an empty FIFO.
- FIFO:
  - Circular buffer with pointers of width clog2(DEPTH)+1, wrapping naturally.
  - full = level==DEPTH; empty = level==0.
  - m_data = mem[rd_ptr], registered read not required.
  - Pop when m_valid&m_ready.
  - Simultaneous push and pop: level unchanged, both pointers advance. This is legal when full, since full is evaluated before the pop only in STALL; STALL exits one cycle after the pop frees space.
  - Pop while empty is ignored.
- Reset mid-handshake (ack_out=1): ack_out drops immediately. Upstream sees ack low and must re-handshake; the word already pushed is lost with the FIFO.
- c_in falling while in STALL (protocol violation): remain in STALL; push on space; ACK_HI then exits as soon as c_sync=0.

Decomposition:
- Shared package muller_c_pkg holds:
  - FSM state enum: IDLE, STALL, ACK_HI.
  - Default constants: DATA_W, DEPTH, SYNC_STAGES.
  - clog2 helper.
- One sub-module, muller_c_sync: parameterised SYNC_STAGES flop chain with async active-low reset. It is reused for any other asynchronous level entering the clock domain.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset and single capture:
  - Stimulus: rst_n low then high; data_in=4'hA; c_in rises at cycle 5.
  - Response: push at cycle 7, ack_out=1 at 8, m_valid=1 at 8, m_data=4'hA, xfer_cnt=1.
  - Then c_in low -> ack_out=0 two to three cycles later.
- Fill and stall:
  - Stimulus: m_ready=0; four handshakes with data 1,2,3,4, then a fifth with data 5.
  - Response: level=4; stall=1 and ack_out stays 0 for the fifth handshake.
  - Then m_ready=1 for one cycle -> m_data=1 popped; the next cycle pushes 5, ack_out=1, level=4.
- Streaming: m_ready=1 held; 20 back-to-back handshakes with incrementing data -> output order 0..19 exact, level never exceeds 1, xfer_cnt=20.
- Pointer wrap: DEPTH=4; 9 pushes interleaved with pops -> data order preserved across two wraps.
- Reset mid-operation: assert rst_n low while ack_out=1 with level=2 -> ack_out, m_valid and level go to 0 without waiting for a clock edge.
- Counter wrap: CNT_W=4; 17 handshakes -> xfer_cnt=1.
